// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions: destination tags, forwarding select encodings
// consumed by the operand muxes, scoreboard/FSM types and the HI/LO select helper.
package fwd_hazard_ctrl_pkg;

    localparam logic [5:0] TAG_HI   = 6'd32;
    localparam logic [5:0] TAG_LO   = 6'd33;
    localparam logic [5:0] TAG_PROD = 6'd34;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EM  = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [2:0] FWD3_IDEX    = 3'b000;
    localparam logic [2:0] FWD3_WB_ALU  = 3'b001;
    localparam logic [2:0] FWD3_EM_ALU  = 3'b010;
    localparam logic [2:0] FWD3_WB_PROD = 3'b011;
    localparam logic [2:0] FWD3_EM_PROD = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } busy_state_t;

    // HI/LO operand select: a full product beats a single-register move within
    // the same stage, and the younger (EX/MEM) stage beats MEM/WB.
    function automatic logic [2:0] hilo_sel(
        input logic [5:0] em_dst,
        input logic       em_wr,
        input logic [5:0] wb_dst,
        input logic       wb_wr,
        input logic [5:0] tag
    );
        logic [2:0] sel;
        sel = FWD3_IDEX;
        if (em_wr && em_dst == TAG_PROD)      sel = FWD3_EM_PROD;
        else if (em_wr && em_dst == tag)      sel = FWD3_EM_ALU;
        else if (wb_wr && wb_dst == TAG_PROD) sel = FWD3_WB_PROD;
        else if (wb_wr && wb_dst == tag)      sel = FWD3_WB_ALU;
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// GPR tag compare against a near and a far pipeline stage with near-stage
// priority. Register 0 and the HI/LO/PROD tags never match.
module fwd_hazard_ctrl_match
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [5:0] near_dst,
    input  logic       near_wr,
    input  logic [5:0] far_dst,
    input  logic       far_wr,
    output logic [1:0] sel
);

    logic src_nz;
    logic near_hit;
    logic far_hit;

    // Zero-extending the source keeps dst tags >= 32 from ever matching.
    always_comb begin
        src_nz   = (src != 5'd0);
        near_hit = near_wr && src_nz && (near_dst == {1'b0, src});
        far_hit  = far_wr  && src_nz && (far_dst  == {1'b0, src});
        sel      = FWD_REG;
        if (near_hit)     sel = FWD_EM;
        else if (far_hit) sel = FWD_WB;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadow EX/MEM and MEM/WB destination
// scoreboards, forwarding selects for ID, EX and HI/LO operands, stall/bubble
// generation and the multiply-busy sequencer.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no multi-cycle product in flight; EX/MEM tracks ID/EX
//  ST_BUSY | product occupying EX; cnt counts remaining cycles, PROD
//          | tag held in EX/MEM, ID readers of HI/LO are stalled
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_use,
    input  logic       id_rt_use,
    input  logic       id_branch,
    input  logic       id_hilo_use,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [5:0] ex_dst,
    input  logic       ex_regwrite,
    input  logic       ex_memtoreg,
    input  logic       ex_rd_lo,
    input  logic       ex_rd_hi,
    output logic [1:0] Forward1A,
    output logic [1:0] Forward1B,
    output logic [1:0] Forward2A,
    output logic [1:0] Forward2B,
    output logic [2:0] Forward3A,
    output logic [2:0] Forward3B,
    output logic       stall,
    output logic       OR3_out,
    output logic       mul_busy
);

    busy_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [5:0] em_dst;
    logic       em_wr;
    logic       em_mtr;
    logic [5:0] wb_dst;
    logic       wb_wr;

    logic       em_alu_wr;
    logic [1:0] hz_rs_sel;
    logic [1:0] hz_rt_sel;
    logic       rs_ex_hit, rt_ex_hit, rs_em_hit, rt_em_hit;
    logic       src_ex_hit, src_em_hit;

    // Scoreboard shift; the PROD entry stays in EX/MEM while the multiplier is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_dst <= 6'd0;
            em_wr  <= 1'b0;
            em_mtr <= 1'b0;
            wb_dst <= 6'd0;
            wb_wr  <= 1'b0;
        end else if (flush) begin
            em_dst <= 6'd0;
            em_wr  <= 1'b0;
            em_mtr <= 1'b0;
            wb_dst <= 6'd0;
            wb_wr  <= 1'b0;
        end else begin
            wb_dst <= em_dst;
            wb_wr  <= em_wr;
            if (state != ST_BUSY) begin
                em_dst <= ex_dst;
                em_wr  <= ex_regwrite;
                em_mtr <= ex_memtoreg;
            end
        end
    end

    // Busy sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Busy sequencer next state: load MUL_LAT-1 on a product write, leave at terminal count 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MUL_LAT > 1 && ex_regwrite && ex_dst == TAG_PROD) begin
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CNT_W'(MUL_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A load in EX/MEM has no data yet, so the ID comparator may not take it.
    assign em_alu_wr = em_wr & ~em_mtr;

    fwd_hazard_ctrl_match u_fwd1a (
        .src(id_rs), .near_dst(em_dst), .near_wr(em_alu_wr),
        .far_dst(wb_dst), .far_wr(wb_wr), .sel(Forward1A)
    );
    fwd_hazard_ctrl_match u_fwd1b (
        .src(id_rt), .near_dst(em_dst), .near_wr(em_alu_wr),
        .far_dst(wb_dst), .far_wr(wb_wr), .sel(Forward1B)
    );
    fwd_hazard_ctrl_match u_fwd2a (
        .src(ex_rs), .near_dst(em_dst), .near_wr(em_wr),
        .far_dst(wb_dst), .far_wr(wb_wr), .sel(Forward2A)
    );
    fwd_hazard_ctrl_match u_fwd2b (
        .src(ex_rt), .near_dst(em_dst), .near_wr(em_wr),
        .far_dst(wb_dst), .far_wr(wb_wr), .sel(Forward2B)
    );

    // ID sources against ID/EX (near) and EX/MEM (far) for hazard detection.
    fwd_hazard_ctrl_match u_hz_rs (
        .src(id_rs), .near_dst(ex_dst), .near_wr(ex_regwrite),
        .far_dst(em_dst), .far_wr(em_wr), .sel(hz_rs_sel)
    );
    fwd_hazard_ctrl_match u_hz_rt (
        .src(id_rt), .near_dst(ex_dst), .near_wr(ex_regwrite),
        .far_dst(em_dst), .far_wr(em_wr), .sel(hz_rt_sel)
    );

    // Stall sources; a far hit hidden by a near hit already stalls through the near term.
    always_comb begin
        rs_ex_hit  = id_rs_use && (hz_rs_sel == FWD_EM);
        rt_ex_hit  = id_rt_use && (hz_rt_sel == FWD_EM);
        rs_em_hit  = id_rs_use && (hz_rs_sel == FWD_WB);
        rt_em_hit  = id_rt_use && (hz_rt_sel == FWD_WB);
        src_ex_hit = rs_ex_hit || rt_ex_hit;
        src_em_hit = rs_em_hit || rt_em_hit;
        mul_busy   = (state == ST_BUSY);
        stall      = !rst && ((ex_memtoreg && src_ex_hit)
                           || (id_branch && src_ex_hit)
                           || (id_branch && em_mtr && src_em_hit)
                           || (id_hilo_use && mul_busy));
        OR3_out    = stall;
    end

    // HI/LO operand selects for the EX stage.
    always_comb begin
        Forward3A = ex_rd_lo ? hilo_sel(em_dst, em_wr, wb_dst, wb_wr, TAG_LO) : FWD3_IDEX;
        Forward3B = ex_rd_hi ? hilo_sel(em_dst, em_wr, wb_dst, wb_wr, TAG_HI) : FWD3_IDEX;
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for the forwarding/hazard controller.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush;
    logic [4:0] id_rs, id_rt;
    logic       id_rs_use, id_rt_use, id_branch, id_hilo_use;
    logic [4:0] ex_rs, ex_rt;
    logic [5:0] ex_dst;
    logic       ex_regwrite, ex_memtoreg, ex_rd_lo, ex_rd_hi;
    logic [1:0] Forward1A, Forward1B, Forward2A, Forward2B;
    logic [2:0] Forward3A, Forward3B;
    logic       stall, OR3_out, mul_busy;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.MUL_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
        .id_branch(id_branch), .id_hilo_use(id_hilo_use),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_rd_lo(ex_rd_lo), .ex_rd_hi(ex_rd_hi),
        .Forward1A(Forward1A), .Forward1B(Forward1B), .Forward2A(Forward2A),
        .Forward2B(Forward2B), .Forward3A(Forward3A), .Forward3B(Forward3B),
        .stall(stall), .OR3_out(OR3_out), .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush = 0;
        id_rs = 0; id_rt = 0; id_rs_use = 0; id_rt_use = 0; id_branch = 0; id_hilo_use = 0;
        ex_rs = 0; ex_rt = 0; ex_dst = 0; ex_regwrite = 0; ex_memtoreg = 0;
        ex_rd_lo = 0; ex_rd_hi = 0;
    endtask

    task automatic set_ex(input logic [5:0] dst, input logic wr, input logic mtr);
        ex_dst = dst; ex_regwrite = wr; ex_memtoreg = mtr;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic rs_use,
                          input logic rt_use, input logic br, input logic hilo);
        id_rs = rs; id_rt = rt; id_rs_use = rs_use; id_rt_use = rt_use;
        id_branch = br; id_hilo_use = hilo;
    endtask

    task automatic drain();
        set_idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle();
        #3;
        checks++;
        if ({Forward1A, Forward1B, Forward2A, Forward2B, Forward3A, Forward3B, stall, OR3_out, mul_busy} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {Forward1A, Forward1B, Forward2A, Forward2B, Forward3A, Forward3B, stall, OR3_out, mul_busy});
        end
        set_ex(6'd5, 1, 1); set_id(5'd5, 5'd0, 1, 0, 0, 0); ex_rd_lo = 1;
        #1;
        checks++;
        if ({Forward3A, stall, OR3_out} !== 5'd0) begin
            errors++; $display("FAIL reset_hold: got F3A=%b stall=%b or3=%b expected 000 0 0", Forward3A, stall, OR3_out);
        end
        @(negedge clk);
        rst = 0;
        set_idle();
        tick();
    endtask

    task automatic test_ex_forward();
        drain();
        set_ex(6'd3, 1, 0);
        tick();
        set_ex(6'd4, 1, 0); ex_rs = 5'd3; ex_rt = 5'd1;
        #1;
        checks++; if (Forward2A !== 2'b10) begin errors++; $display("FAIL ex_fwd_em_rs: got %b expected 10", Forward2A); end
        checks++; if (Forward2B !== 2'b00) begin errors++; $display("FAIL ex_fwd_none_rt: got %b expected 00", Forward2B); end
        tick();
        set_ex(6'd8, 1, 0); ex_rs = 5'd3; ex_rt = 5'd4;
        #1;
        checks++; if (Forward2A !== 2'b01) begin errors++; $display("FAIL ex_fwd_wb_rs: got %b expected 01", Forward2A); end
        checks++; if (Forward2B !== 2'b10) begin errors++; $display("FAIL ex_fwd_em_rt: got %b expected 10", Forward2B); end
        tick();
        set_ex(6'd9, 1, 0); ex_rs = 0; ex_rt = 0;
        tick();
        set_ex(6'd9, 1, 0);
        tick();
        set_ex(6'd0, 0, 0); ex_rs = 5'd9; ex_rt = 5'd8;
        #1;
        checks++; if (Forward2A !== 2'b10) begin errors++; $display("FAIL ex_fwd_priority: got %b expected 10", Forward2A); end
        checks++; if (Forward2B !== 2'b00) begin errors++; $display("FAIL ex_fwd_aged_out: got %b expected 00", Forward2B); end
        tick();
        set_ex(6'd0, 1, 0); ex_rs = 0; ex_rt = 0;
        tick();
        set_ex(6'd0, 0, 0); ex_rs = 5'd0; set_id(5'd0, 5'd0, 1, 0, 0, 0);
        #1;
        checks++; if (Forward2A !== 2'b00) begin errors++; $display("FAIL r0_ex_fwd: got %b expected 00", Forward2A); end
        checks++; if (Forward1A !== 2'b00) begin errors++; $display("FAIL r0_id_fwd: got %b expected 00", Forward1A); end
        set_ex(6'd5, 0, 0); set_id(5'd0, 5'd0, 0, 0, 0, 0);
        tick();
        set_ex(6'd0, 0, 0); ex_rs = 5'd5;
        #1;
        checks++; if (Forward2A !== 2'b00) begin errors++; $display("FAIL no_regwrite_fwd: got %b expected 00", Forward2A); end
    endtask

    task automatic test_load_use();
        drain();
        set_ex(6'd5, 1, 1); set_id(5'd0, 5'd5, 0, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_unused_rt: got %b expected 0", stall); end
        set_id(5'd5, 5'd0, 1, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", stall); end
        checks++; if (OR3_out !== 1'b1) begin errors++; $display("FAIL load_use_bubble: got %b expected 1", OR3_out); end
        tick();
        set_ex(6'd0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0 || OR3_out !== 1'b0) begin errors++; $display("FAIL load_use_release: stall=%b or3=%b expected 0 0", stall, OR3_out); end
        checks++; if (Forward1A !== 2'b00) begin errors++; $display("FAIL load_no_id_fwd: got %b expected 00", Forward1A); end
        tick();
        set_ex(6'd7, 1, 0); ex_rs = 5'd5; set_id(5'd0, 5'd0, 0, 0, 0, 0);
        #1;
        checks++; if (Forward2A !== 2'b01) begin errors++; $display("FAIL load_use_fwd_wb: got %b expected 01", Forward2A); end
    endtask

    task automatic test_branch();
        drain();
        set_ex(6'd7, 1, 0); set_id(5'd7, 5'd0, 1, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_use_no_stall: got %b expected 0", stall); end
        set_ex(6'd6, 1, 1); set_id(5'd6, 5'd0, 1, 1, 1, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_beq_stall1: got %b expected 1", stall); end
        tick();
        set_ex(6'd0, 0, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_beq_stall2: got %b expected 1", stall); end
        checks++; if (Forward1A !== 2'b00) begin errors++; $display("FAIL lw_beq_fwd_c2: got %b expected 00", Forward1A); end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_beq_release: got %b expected 0", stall); end
        checks++; if (Forward1A !== 2'b01 || Forward1B !== 2'b00) begin errors++; $display("FAIL lw_beq_fwd_c3: got %b %b expected 01 00", Forward1A, Forward1B); end
        drain();
        set_ex(6'd7, 1, 0); set_id(5'd7, 5'd7, 1, 1, 1, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL add_beq_stall: got %b expected 1", stall); end
        tick();
        set_ex(6'd0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_beq_release: got %b expected 0", stall); end
        checks++; if (Forward1A !== 2'b10 || Forward1B !== 2'b10) begin errors++; $display("FAIL add_beq_fwd: got %b %b expected 10 10", Forward1A, Forward1B); end
    endtask

    task automatic test_mul();
        drain();
        set_ex(6'd34, 1, 0); set_id(5'd0, 5'd0, 0, 0, 0, 1);
        #1;
        checks++; if (mul_busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mult_issue: busy=%b stall=%b expected 0 0", mul_busy, stall); end
        tick();
        set_ex(6'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || mul_busy !== 1'b1 || OR3_out !== 1'b1) begin
                errors++; $display("FAIL mult_stall_cycle%0d: stall=%b busy=%b or3=%b expected 1 1 1", i, stall, mul_busy, OR3_out);
            end
            tick();
        end
        ex_rd_lo = 1; ex_rd_hi = 1;
        #1;
        checks++; if (stall !== 1'b0 || mul_busy !== 1'b0) begin errors++; $display("FAIL mult_done: stall=%b busy=%b expected 0 0", stall, mul_busy); end
        checks++; if (Forward3A !== 3'b100 || Forward3B !== 3'b100) begin errors++; $display("FAIL mult_fwd_em: got %b %b expected 100 100", Forward3A, Forward3B); end
        tick();
        ex_rd_hi = 0;
        #1;
        checks++; if (Forward3A !== 3'b011) begin errors++; $display("FAIL mult_fwd_wb: got %b expected 011", Forward3A); end
        checks++; if (Forward3B !== 3'b000) begin errors++; $display("FAIL mult_hi_unread: got %b expected 000", Forward3B); end
    endtask

    task automatic test_mtlo();
        drain();
        set_ex(6'd33, 1, 0);
        tick();
        set_ex(6'd0, 0, 0); ex_rd_lo = 1; ex_rd_hi = 1;
        #1;
        checks++; if (Forward3A !== 3'b010 || Forward3B !== 3'b000) begin errors++; $display("FAIL mtlo_fwd_em: got %b %b expected 010 000", Forward3A, Forward3B); end
        tick();
        #1;
        checks++; if (Forward3A !== 3'b001 || Forward3B !== 3'b000) begin errors++; $display("FAIL mtlo_fwd_wb: got %b %b expected 001 000", Forward3A, Forward3B); end
        set_ex(6'd32, 1, 0);
        tick();
        set_ex(6'd0, 0, 0);
        #1;
        checks++; if (Forward3B !== 3'b010 || Forward3A !== 3'b000) begin errors++; $display("FAIL mthi_fwd_em: got %b %b expected 010 000", Forward3B, Forward3A); end
    endtask

    task automatic test_rst_busy();
        drain();
        set_ex(6'd34, 1, 0); set_id(5'd0, 5'd0, 0, 0, 0, 1);
        tick();
        set_ex(6'd0, 0, 0);
        #1;
        checks++; if (stall !== 1'b1 || mul_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: stall=%b busy=%b expected 1 1", stall, mul_busy); end
        #1;
        rst = 1;
        #1;
        checks++; if (mul_busy !== 1'b0 || stall !== 1'b0 || OR3_out !== 1'b0) begin errors++; $display("FAIL rst_async_drop: busy=%b stall=%b or3=%b expected 0 0 0", mul_busy, stall, OR3_out); end
        set_ex(6'd5, 1, 1); set_id(5'd5, 5'd0, 1, 0, 0, 1);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_load_use: got %b expected 0", stall); end
        @(negedge clk);
        rst = 0;
        set_idle();
        tick();
    endtask

    task automatic test_flush_busy();
        drain();
        set_ex(6'd34, 1, 0); set_id(5'd0, 5'd0, 0, 0, 0, 1);
        tick();
        set_ex(6'd0, 0, 0); flush = 1;
        #1;
        checks++; if (mul_busy !== 1'b1) begin errors++; $display("FAIL flush_sync: busy=%b expected 1", mul_busy); end
        tick();
        flush = 0; ex_rd_lo = 1;
        #1;
        checks++; if (mul_busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_idle: busy=%b stall=%b expected 0 0", mul_busy, stall); end
        checks++; if (Forward3A !== 3'b000) begin errors++; $display("FAIL flush_clears_prod: got %b expected 000", Forward3A); end
        set_idle();
        set_ex(6'd3, 1, 0);
        tick();
        set_ex(6'd0, 0, 0); flush = 1;
        tick();
        flush = 0; ex_rs = 5'd3;
        #1;
        checks++; if (Forward2A !== 2'b00) begin errors++; $display("FAIL flush_clears_gpr: got %b expected 00", Forward2A); end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_branch();
        test_mul();
        test_mtlo();
        test_rst_busy();
        test_flush_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
